// File: rtl/decoder_sweep.sv
// One-hot line decoder with an optional self-timed ascending sweep of every line.
// All outputs are registered; the sweep counter always matches the line currently on sel.
module decoder_sweep #(
    parameter int ADDR_W       = 5,
    parameter int PROTECT_ZERO = 1,
    parameter int SWEEP_EN     = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    wr_req,
    input  logic                    sweep_start,
    output logic [(1<<ADDR_W)-1:0]  sel,
    output logic                    sel_valid,
    output logic                    busy,
    output logic                    sweep_done
);

    localparam int N = 1 << ADDR_W;
    localparam bit PZ_ON    = (PROTECT_ZERO != 0);
    localparam bit SWEEP_ON = (SWEEP_EN != 0);
    localparam logic [ADDR_W-1:0] LAST  = '1;
    localparam logic [ADDR_W-1:0] FIRST = PZ_ON ? ADDR_W'(1) : '0;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [N-1:0]      sel_nxt;
    logic              done_nxt;

    function automatic logic [N-1:0] one_hot(input logic [ADDR_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            sel_valid  <= |sel_nxt;
            busy       <= (state_nxt == SWEEP);
            sweep_done <= done_nxt;
        end
    end

    // The counter is loaded/advanced on the same edge that puts its line on sel,
    // so done is flagged when the next count reaches the last line.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = '0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (SWEEP_ON && sweep_start) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = FIRST;
                    sel_nxt   = one_hot(FIRST);
                    done_nxt  = (FIRST == LAST);
                end else if (wr_req && !(PZ_ON && addr == '0)) begin
                    sel_nxt = one_hot(addr);
                end
            end
            SWEEP: begin
                // Requests arriving here are dropped, including on the final line.
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = cnt + ADDR_W'(1);
                    sel_nxt  = one_hot(cnt_nxt);
                    done_nxt = (cnt_nxt == LAST);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_sweep.sv
// Bench for decoder_sweep: three parameterisations share one stimulus stream and are
// compared each cycle against a plan-list reference model.
module tb_decoder_sweep;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  addr = '0;
    logic        wr_req = 1'b0;
    logic        sweep_start = 1'b0;

    logic [31:0] sel_d;  logic v_d, b_d, d_d;
    logic [31:0] sel_p;  logic v_p, b_p, d_p;
    logic [7:0]  sel_s;  logic v_s, b_s, d_s;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    decoder_sweep #(.ADDR_W(5), .PROTECT_ZERO(1), .SWEEP_EN(1)) u_def (
        .clock(clock), .reset_n(reset_n), .addr(addr), .wr_req(wr_req),
        .sweep_start(sweep_start), .sel(sel_d), .sel_valid(v_d), .busy(b_d), .sweep_done(d_d));

    decoder_sweep #(.ADDR_W(5), .PROTECT_ZERO(0), .SWEEP_EN(1)) u_pz0 (
        .clock(clock), .reset_n(reset_n), .addr(addr), .wr_req(wr_req),
        .sweep_start(sweep_start), .sel(sel_p), .sel_valid(v_p), .busy(b_p), .sweep_done(d_p));

    decoder_sweep #(.ADDR_W(3), .PROTECT_ZERO(1), .SWEEP_EN(0)) u_se0 (
        .clock(clock), .reset_n(reset_n), .addr(addr[2:0]), .wr_req(wr_req),
        .sweep_start(sweep_start), .sel(sel_s), .sel_valid(v_s), .busy(b_s), .sweep_done(d_s));

    // Reference model: a sweep is a precomputed list of lines walked one per cycle.
    int          aw[3] = '{5, 5, 3};
    int          pz[3] = '{1, 0, 1};
    int          se[3] = '{1, 1, 0};
    int          plan[3][32];
    int          plen[3];
    int          pos[3];
    bit          swp[3];
    logic [31:0] esel[3];
    bit          ebusy[3];
    bit          edone[3];

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            swp[c] = 0; pos[c] = 0; plen[c] = 0;
            esel[c] = '0; ebusy[c] = 0; edone[c] = 0;
        end
    endtask

    task automatic model_edge(input bit wr, input logic [4:0] a, input bit ss);
        for (int c = 0; c < 3; c++) begin
            int n;
            int line;
            n    = 1 << aw[c];
            line = -1;
            if (swp[c]) begin
                pos[c]++;
                if (pos[c] < plen[c]) line = plan[c][pos[c]];
                else swp[c] = 0;
            end else if (se[c] != 0 && ss) begin
                plen[c] = 0;
                for (int k = pz[c]; k < n; k++) begin
                    plan[c][plen[c]] = k;
                    plen[c]++;
                end
                pos[c] = 0;
                swp[c] = 1;
                line   = plan[c][0];
            end else if (wr) begin
                line = int'(a) % n;
                if (pz[c] != 0 && line == 0) line = -1;
            end
            esel[c] = '0;
            if (line >= 0) esel[c][line] = 1'b1;
            ebusy[c] = swp[c];
            edone[c] = swp[c] && (pos[c] == plen[c] - 1);
        end
    endtask

    function automatic logic [34:0] obs(input int c);
        case (c)
            0:       return {sel_d, v_d, b_d, d_d};
            1:       return {sel_p, v_p, b_p, d_p};
            default: return {24'd0, sel_s, v_s, b_s, d_s};
        endcase
    endfunction

    function automatic logic [34:0] expv(input int c);
        return {esel[c], (esel[c] != '0), ebusy[c], edone[c]};
    endfunction

    task automatic step(input bit wr, input logic [4:0] a, input bit ss);
        @(negedge clock);
        wr_req = wr; addr = a; sweep_start = ss;
        @(posedge clock);
        model_edge(wr, a, ss);
        #1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (obs(c) !== 35'd0) begin
                mismatched++;
                $display("FAIL reset cfg=%0d got=%h want=0", c, obs(c));
            end
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_decode_all();
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 5'(a), 1'b0);
            for (int c = 0; c < 2; c++) begin
                compared++;
                if (obs(c) !== expv(c)) begin
                    mismatched++;
                    $display("FAIL decode cfg=%0d addr=%0d got=%h want=%h", c, a, obs(c), expv(c));
                end
            end
        end
        step(1'b0, 5'd0, 1'b0);
        compared++;
        if ({sel_d, v_d} !== 33'd0) begin
            mismatched++;
            $display("FAIL decode_hold got=%h want=0", {sel_d, v_d});
        end
    endtask

    task automatic test_sweep_default();
        int busy_cnt, done_cnt, done_at;
        step(1'b0, 5'd0, 1'b1);
        compared++;
        if (sel_d !== 32'h2) begin
            mismatched++;
            $display("FAIL sweep_first got=%h want=00000002", sel_d);
        end
        busy_cnt = b_d; done_cnt = d_d; done_at = d_d ? 1 : 0;
        for (int i = 2; i <= 33; i++) begin
            if (i <= 32) step(1'($urandom % 2), 5'($urandom % 32), 1'($urandom % 2));
            else step(1'b0, 5'd0, 1'b0);
            compared++;
            if (obs(0) !== expv(0)) begin
                mismatched++;
                $display("FAIL sweep cyc=%0d got=%h want=%h", i, obs(0), expv(0));
            end
            busy_cnt += b_d;
            if (d_d) begin done_cnt++; done_at = i; end
        end
        compared++;
        if (busy_cnt != 31 || done_cnt != 1 || done_at != 31) begin
            mismatched++;
            $display("FAIL sweep_len busy=%0d done=%0d at=%0d want 31/1/31", busy_cnt, done_cnt, done_at);
        end
    endtask

    task automatic test_collision();
        step(1'b1, 5'd7, 1'b1);
        compared++;
        if (sel_d !== 32'h2 || b_d !== 1'b1) begin
            mismatched++;
            $display("FAIL collide_first sel=%h busy=%b want 00000002/1", sel_d, b_d);
        end
        for (int i = 2; i <= 33; i++) begin
            step((i == 5 || i == 12), 5'd3, (i == 9 || i == 20));
            compared++;
            if (obs(0) !== expv(0)) begin
                mismatched++;
                $display("FAIL collide cyc=%0d got=%h want=%h", i, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_pz0();
        int busy_cnt;
        logic [31:0] done_sel;
        busy_cnt = 0; done_sel = '0;
        step(1'b0, 5'd0, 1'b1);
        compared++;
        if (sel_p !== 32'h1) begin
            mismatched++;
            $display("FAIL pz0_first got=%h want=00000001", sel_p);
        end
        busy_cnt = b_p;
        for (int i = 2; i <= 33; i++) begin
            step(1'b0, 5'd0, 1'b0);
            compared++;
            if (obs(1) !== expv(1)) begin
                mismatched++;
                $display("FAIL pz0 cyc=%0d got=%h want=%h", i, obs(1), expv(1));
            end
            busy_cnt += b_p;
            if (d_p) done_sel = sel_p;
        end
        compared++;
        if (busy_cnt != 32 || done_sel !== 32'h8000_0000) begin
            mismatched++;
            $display("FAIL pz0_len busy=%0d done_sel=%h want 32/80000000", busy_cnt, done_sel);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 5'd0, 1'b0);
        compared++;
        if (sel_d !== 32'h400) begin
            mismatched++;
            $display("FAIL ares_line10 got=%h want=00000400", sel_d);
        end
        #2 reset_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (obs(c) !== 35'd0) begin
                mismatched++;
                $display("FAIL ares_clear cfg=%0d got=%h want=0", c, obs(c));
            end
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 5'd5, 1'b0);
        compared++;
        if (sel_d !== 32'h20 || v_d !== 1'b1 || b_d !== 1'b0) begin
            mismatched++;
            $display("FAIL ares_after sel=%h v=%b busy=%b want 00000020/1/0", sel_d, v_d, b_d);
        end
    endtask

    task automatic test_sweep_en0();
        step(1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({sel_s, v_s, b_s, d_s} !== 11'd0) begin
                mismatched++;
                $display("FAIL se0_idle i=%0d got=%h want=0", i, {sel_s, v_s, b_s, d_s});
            end
            step(1'b0, 5'd0, 1'b0);
        end
        step(1'b1, 5'd6, 1'b0);
        compared++;
        if (sel_s !== 8'h40 || v_s !== 1'b1 || b_s !== 1'b0) begin
            mismatched++;
            $display("FAIL se0_decode sel=%h v=%b busy=%b want 40/1/0", sel_s, v_s, b_s);
        end
        // Let the other instances finish any sweep started above.
        for (int i = 0; i < 34; i++) step(1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom % 2), 5'($urandom % 32), ($urandom % 16) == 0);
            for (int c = 0; c < 3; c++) begin
                compared++;
                if (obs(c) !== expv(c)) begin
                    mismatched++;
                    $display("FAIL random cyc=%0d cfg=%0d got=%h want=%h", i, c, obs(c), expv(c));
                end
            end
            compared++;
            if ($countones(sel_d) > 1 || v_d !== (|sel_d) || $countones(sel_p) > 1 || v_p !== (|sel_p)) begin
                mismatched++;
                $display("FAIL invariant cyc=%0d sel_d=%h v_d=%b sel_p=%h v_p=%b", i, sel_d, v_d, sel_p, v_p);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_decode_all();
        test_sweep_default();
        test_collision();
        test_pz0();
        test_async_reset();
        test_sweep_en0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
